// File: rtl/apb_to_csr_ext_req_bridge_if.sv
// Bus bundle between the APB master / CSR responder side and the APB-to-CSR request bridge.
// Signal names keep the bridge's own i_/o_ view so both modports read the same way.
interface apb_to_csr_ext_req_bridge_if #(
    parameter int WORD_BIT_WIDTH      = 32,
    parameter int BYTE_ADDR_BIT_WIDTH = 8
) ();
    logic                             i_psel;
    logic                             i_penable;
    logic                             i_pwrite;
    logic [BYTE_ADDR_BIT_WIDTH-1:0]   i_paddr;
    logic [WORD_BIT_WIDTH-1:0]        i_pwdata;
    logic [WORD_BIT_WIDTH/8-1:0]      i_pstrb;
    logic                             o_pready;
    logic [WORD_BIT_WIDTH-1:0]        o_prdata;
    logic                             o_pslverr;
    logic                             o_acc_req;
    logic                             o_acc_req_is_wr;
    logic [BYTE_ADDR_BIT_WIDTH-1:0]   o_byte_addr;
    logic [WORD_BIT_WIDTH-1:0]        o_wr_data;
    logic [WORD_BIT_WIDTH-1:0]        o_wr_bit_en;
    logic                             i_rd_ack;
    logic [WORD_BIT_WIDTH-1:0]        i_rd_data;
    logic                             i_wr_ack;

    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
        input  i_rd_ack, i_rd_data, i_wr_ack,
        output o_pready, o_prdata, o_pslverr,
        output o_acc_req, o_acc_req_is_wr, o_byte_addr, o_wr_data, o_wr_bit_en
    );

    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata, i_pstrb,
        output i_rd_ack, i_rd_data, i_wr_ack,
        input  o_pready, o_prdata, o_pslverr,
        input  o_acc_req, o_acc_req_is_wr, o_byte_addr, o_wr_data, o_wr_bit_en
    );
endinterface

// File: rtl/apb_to_csr_ext_req_bridge.sv
// APB4 slave that turns each transfer into one single-cycle CSR access request,
// waits for the matching ack (bounded by a timeout) and answers with PREADY/PSLVERR.
module apb_to_csr_ext_req_bridge #(
    parameter int WORD_BIT_WIDTH      = 32,
    parameter int BYTE_ADDR_BIT_WIDTH = 8,
    parameter int TIMEOUT_CYCLES      = 16
) (
    input logic                        i_clk,
    input logic                        i_async_rst,
    apb_to_csr_ext_req_bridge_if.slave bus
);
    localparam int STRB_W     = WORD_BIT_WIDTH / 8;
    localparam int ALIGN_BITS = $clog2(STRB_W);
    localparam int CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BYTE_ADDR_BIT_WIDTH-1:0] ADDR_MASK =
        ~BYTE_ADDR_BIT_WIDTH'((1 << ALIGN_BITS) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             acc_req_q, acc_req_d;
    logic                             is_wr_q, is_wr_d;
    logic [BYTE_ADDR_BIT_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_BIT_WIDTH-1:0]        wr_data_q, wr_data_d;
    logic [WORD_BIT_WIDTH-1:0]        bit_en_q, bit_en_d;
    logic [WORD_BIT_WIDTH-1:0]        prdata_q, prdata_d;
    logic                             pslverr_q, pslverr_d;
    logic [WORD_BIT_WIDTH-1:0]        strb_bit_en;
    logic                             ack_match;

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
            assign strb_bit_en[gi*8 +: 8] = {8{bus.i_pstrb[gi]}};
        end
    endgenerate

    // Only the ack matching the captured direction can complete the transfer.
    assign ack_match = is_wr_q ? bus.i_wr_ack : bus.i_rd_ack;

    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_req_q <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            bit_en_q  <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_req_q <= acc_req_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            bit_en_q  <= bit_en_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_req_d = 1'b0;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        bit_en_d  = bit_en_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_psel && bus.i_penable) begin
                    is_wr_d   = bus.i_pwrite;
                    addr_d    = bus.i_paddr & ADDR_MASK;
                    wr_data_d = bus.i_pwdata;
                    bit_en_d  = bus.i_pwrite ? strb_bit_en : '0;
                    acc_req_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Checking the ack first lets it win over a simultaneous timeout.
                if (ack_match) begin
                    state_d   = ST_RESP;
                    pslverr_d = 1'b0;
                    prdata_d  = is_wr_q ? '0 : bus.i_rd_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    pslverr_d = 1'b1;
                    prdata_d  = '0;
                end
            end
            ST_RESP: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                pslverr_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.o_pready        = (state_q == ST_RESP);
    assign bus.o_prdata        = prdata_q;
    assign bus.o_pslverr       = pslverr_q;
    assign bus.o_acc_req       = acc_req_q;
    assign bus.o_acc_req_is_wr = is_wr_q;
    assign bus.o_byte_addr     = addr_q;
    assign bus.o_wr_data       = wr_data_q;
    assign bus.o_wr_bit_en     = bit_en_q;
endmodule

// File: tb/tb_apb_to_csr_ext_req_bridge.sv
// Bench for the APB-to-CSR request bridge: transaction-level model compared every cycle,
// plus directed transfers with hand-computed results.
module tb_apb_to_csr_ext_req_bridge;
    localparam int W  = 32;
    localparam int A  = 8;
    localparam int TO = 16;

    localparam int K_NONE  = 0;
    localparam int K_MATCH = 1;
    localparam int K_WRONG = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_to_csr_ext_req_bridge_if #(.WORD_BIT_WIDTH(W), .BYTE_ADDR_BIT_WIDTH(A)) bus ();

    apb_to_csr_ext_req_bridge #(
        .WORD_BIT_WIDTH(W), .BYTE_ADDR_BIT_WIDTH(A), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_async_rst(rst), .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{s[i]}};
        return m;
    endfunction

    // Transaction-level model: one outstanding transfer, answered on the first matching
    // ack or after TO waited cycles, followed by a single response cycle.
    logic          m_busy, m_resp;
    int            m_age;
    logic          e_req, e_wr, e_pready, e_err;
    logic [A-1:0]  e_addr;
    logic [W-1:0]  e_wdata, e_ben, e_prdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_resp <= 1'b0; m_age <= 0;
            e_req <= 1'b0; e_wr <= 1'b0; e_pready <= 1'b0; e_err <= 1'b0;
            e_addr <= '0; e_wdata <= '0; e_ben <= '0; e_prdata <= '0;
        end else begin
            e_req <= 1'b0;
            if (m_resp) begin
                m_resp   <= 1'b0;
                e_pready <= 1'b0;
                e_err    <= 1'b0;
            end else if (m_busy) begin
                m_age <= m_age + 1;
                if (e_wr ? bus.i_wr_ack : bus.i_rd_ack) begin
                    m_busy <= 1'b0; m_resp <= 1'b1; e_pready <= 1'b1; e_err <= 1'b0;
                    e_prdata <= e_wr ? 32'h0 : bus.i_rd_data;
                end else if (m_age + 1 >= TO) begin
                    m_busy <= 1'b0; m_resp <= 1'b1; e_pready <= 1'b1; e_err <= 1'b1;
                    e_prdata <= 32'h0;
                end
            end else if (bus.i_psel && bus.i_penable) begin
                e_req   <= 1'b1;
                e_wr    <= bus.i_pwrite;
                e_addr  <= {bus.i_paddr[A-1:2], 2'b00};
                e_wdata <= bus.i_pwdata;
                e_ben   <= bus.i_pwrite ? strb_mask(bus.i_pstrb) : 32'h0;
                m_busy  <= 1'b1;
                m_age   <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("pready",  32'(bus.o_pready),        32'(e_pready));
            chk("pslverr", 32'(bus.o_pslverr),       32'(e_err));
            chk("prdata",  bus.o_prdata,             e_prdata);
            chk("acc_req", 32'(bus.o_acc_req),       32'(e_req));
            chk("is_wr",   32'(bus.o_acc_req_is_wr), 32'(e_wr));
            chk("addr",    32'(bus.o_byte_addr),     32'(e_addr));
            chk("wr_data", bus.o_wr_data,            e_wdata);
            chk("bit_en",  bus.o_wr_bit_en,          e_ben);
        end
    end

    // Ack responder: index 0 is the o_acc_req cycle, index d is d cycles later.
    int          ack_cnt = -1;
    int          plan_kind = K_NONE, plan_d = -1, plan_late = -1;
    logic        plan_wr = 1'b0;
    logic [31:0] plan_data = 32'h0;
    int          req_count = 0, overlap_err = 0;
    logic        outstanding = 1'b0;
    logic        snap_wr;
    logic [7:0]  snap_addr;
    logic [31:0] snap_wdata, snap_ben;

    always @(negedge clk) begin
        bus.i_rd_ack  = 1'b0;
        bus.i_wr_ack  = 1'b0;
        bus.i_rd_data = 32'h5A5A_0000 ^ 32'(ack_cnt);
        if (rst) outstanding = 1'b0;
        if (bus.o_pready) outstanding = 1'b0;
        if (bus.o_acc_req) begin
            if (outstanding) overlap_err++;
            outstanding = 1'b1;
            ack_cnt     = 0;
            req_count++;
            snap_wr    = bus.o_acc_req_is_wr;
            snap_addr  = bus.o_byte_addr;
            snap_wdata = bus.o_wr_data;
            snap_ben   = bus.o_wr_bit_en;
        end else if (ack_cnt >= 0) begin
            ack_cnt++;
        end
        if (plan_kind != K_NONE) begin
            if ((plan_kind == K_MATCH && ack_cnt == plan_d) ||
                (plan_kind == K_WRONG && ack_cnt == plan_d + 2)) begin
                if (plan_wr) bus.i_wr_ack = 1'b1;
                else begin bus.i_rd_ack = 1'b1; bus.i_rd_data = plan_data; end
            end
            if (plan_kind == K_WRONG && ack_cnt == plan_d) begin
                if (plan_wr) begin bus.i_rd_ack = 1'b1; bus.i_rd_data = 32'hEEEE_EEEE; end
                else bus.i_wr_ack = 1'b1;
            end
        end
        if (ack_cnt == plan_late) begin
            bus.i_rd_ack  = 1'b1;
            bus.i_rd_data = 32'hFFFF_0000;
        end
    end

    task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [31:0] prd,
                            output logic err, output int lat);
        logic done;
        @(negedge clk);
        bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = wr;
        bus.i_paddr = a; bus.i_pwdata = d; bus.i_pstrb = s;
        @(negedge clk);
        bus.i_penable = 1'b1;
        lat = 0; done = 1'b0;
        while (lat < 40 && !done) begin
            @(negedge clk);
            lat++;
            done = bus.o_pready;
        end
        chk("xfer_completed", 32'(done), 32'd1);
        prd = bus.o_prdata;
        err = bus.o_pslverr;
    endtask

    task automatic apb_idle();
        @(negedge clk);
        bus.i_psel = 1'b0; bus.i_penable = 1'b0;
    endtask

    task automatic set_plan(input int kind, input logic wr, input int d, input logic [31:0] data);
        plan_kind = kind; plan_wr = wr; plan_d = d; plan_data = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prd;
        logic        err;
        int          lat, r0;

        bus.i_psel = 1'b0; bus.i_penable = 1'b0; bus.i_pwrite = 1'b0;
        bus.i_paddr = '0; bus.i_pwdata = '0; bus.i_pstrb = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pready",  32'(bus.o_pready),  32'd0);
        chk("rst_acc_req", 32'(bus.o_acc_req), 32'd0);
        chk("rst_prdata",  bus.o_prdata,       32'd0);
        rst = 1'b0;

        // Write, ack one cycle after the request.
        set_plan(K_MATCH, 1'b1, 1, 32'h0);
        r0 = req_count;
        apb_xfer(1'b1, 8'h14, 32'hDEADBEEF, 4'b0101, prd, err, lat);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_err", 32'(err), 32'd0);
        chk("wr_reqs", 32'(req_count - r0), 32'd1);
        chk("wr_addr", 32'(snap_addr), 32'h14);
        chk("wr_ben", snap_ben, 32'h00FF00FF);
        chk("wr_data", snap_wdata, 32'hDEADBEEF);
        chk("wr_is_wr", 32'(snap_wr), 32'd1);
        $display("write 0x14: lat=%0d err=%0d", lat, err);
        apb_idle();

        // Read with a two-cycle ack, unaligned address.
        set_plan(K_MATCH, 1'b0, 2, 32'h12345678);
        apb_xfer(1'b0, 8'h0B, 32'h11111111, 4'hF, prd, err, lat);
        chk("rd_lat", 32'(lat), 32'd4);
        chk("rd_prdata", prd, 32'h12345678);
        chk("rd_addr", 32'(snap_addr), 32'h08);
        chk("rd_is_wr", 32'(snap_wr), 32'd0);
        chk("rd_ben", snap_ben, 32'h0);
        $display("read 0x0B: lat=%0d prdata=0x%08h", lat, prd);
        apb_idle();

        // Timeout, then a late read ack in the following idle.
        set_plan(K_NONE, 1'b0, -1, 32'h0);
        plan_late = 17;
        r0 = req_count;
        apb_xfer(1'b0, 8'h20, 32'h0, 4'h0, prd, err, lat);
        chk("to_lat", 32'(lat), 32'd17);
        chk("to_err", 32'(err), 32'd1);
        chk("to_prdata", prd, 32'h0);
        apb_idle();
        repeat (3) @(negedge clk);
        chk("late_prdata", bus.o_prdata, 32'h0);
        chk("late_err", 32'(bus.o_pslverr), 32'd0);
        chk("late_reqs", 32'(req_count - r0), 32'd1);
        plan_late = -1;
        $display("timeout read 0x20: lat=%0d err=%0d", lat, err);

        // Ack in the same cycle the timeout fires: the ack wins.
        set_plan(K_MATCH, 1'b0, TO - 1, 32'h0F0F1234);
        apb_xfer(1'b0, 8'h24, 32'h0, 4'h0, prd, err, lat);
        chk("edge_lat", 32'(lat), 32'd17);
        chk("edge_err", 32'(err), 32'd0);
        chk("edge_prdata", prd, 32'h0F0F1234);
        $display("edge read 0x24: lat=%0d err=%0d prdata=0x%08h", lat, err, prd);
        apb_idle();

        // Write receives a read ack first, then the real write ack.
        set_plan(K_WRONG, 1'b1, 1, 32'h0);
        apb_xfer(1'b1, 8'h33, 32'h01020304, 4'b1000, prd, err, lat);
        chk("wrong_lat", 32'(lat), 32'd5);
        chk("wrong_err", 32'(err), 32'd0);
        chk("wrong_prdata", prd, 32'h0);
        chk("wrong_addr", 32'(snap_addr), 32'h30);
        chk("wrong_ben", snap_ben, 32'hFF000000);
        $display("wrong-ack write 0x33: lat=%0d err=%0d", lat, err);
        apb_idle();

        // Reset asserted between edges while waiting for an ack.
        set_plan(K_NONE, 1'b0, -1, 32'h0);
        @(negedge clk);
        bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = 1'b1;
        bus.i_paddr = 8'h50; bus.i_pwdata = 32'h77778888; bus.i_pstrb = 4'hF;
        @(negedge clk);
        bus.i_penable = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pready",  32'(bus.o_pready),        32'd0);
        chk("mid_rst_acc_req", 32'(bus.o_acc_req),       32'd0);
        chk("mid_rst_addr",    32'(bus.o_byte_addr),     32'd0);
        chk("mid_rst_is_wr",   32'(bus.o_acc_req_is_wr), 32'd0);
        chk("mid_rst_wdata",   bus.o_wr_data,            32'd0);
        chk("mid_rst_ben",     bus.o_wr_bit_en,          32'd0);
        bus.i_psel = 1'b0; bus.i_penable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("reset mid-wait applied");

        set_plan(K_MATCH, 1'b1, 1, 32'h0);
        r0 = req_count;
        apb_xfer(1'b1, 8'h04, 32'hA5A5A5A5, 4'hF, prd, err, lat);
        chk("post_rst_lat", 32'(lat), 32'd3);
        chk("post_rst_reqs", 32'(req_count - r0), 32'd1);
        chk("post_rst_ben", snap_ben, 32'hFFFFFFFF);
        $display("write 0x04 after reset: lat=%0d err=%0d", lat, err);

        // Back-to-back write then read with no idle cycle between them.
        set_plan(K_MATCH, 1'b1, 1, 32'h0);
        r0 = req_count;
        apb_xfer(1'b1, 8'h40, 32'hCAFEF00D, 4'b0011, prd, err, lat);
        chk("b2b_wr_lat", 32'(lat), 32'd3);
        chk("b2b_wr_ben", snap_ben, 32'h0000FFFF);
        $display("b2b write 0x40: lat=%0d err=%0d", lat, err);
        set_plan(K_MATCH, 1'b0, 1, 32'h0BADF00D);
        apb_xfer(1'b0, 8'h41, 32'h0, 4'h0, prd, err, lat);
        chk("b2b_rd_lat", 32'(lat), 32'd3);
        chk("b2b_rd_prdata", prd, 32'h0BADF00D);
        chk("b2b_rd_addr", 32'(snap_addr), 32'h40);
        chk("b2b_reqs", 32'(req_count - r0), 32'd2);
        $display("b2b read 0x41: lat=%0d prdata=0x%08h", lat, prd);
        apb_idle();
        repeat (2) @(negedge clk);
        chk("no_overlap", 32'(overlap_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
